// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - byte stream to configuration-chain serialiser (MSB first)
// Optional readback CRC-16-CCITT over ccff_tail: define CCFF_READBACK_CRC_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ccff_head,
  output logic             chain_shift_en,
  input  logic             ccff_tail,
`ifdef CCFF_READBACK_CRC_EN
  output logic [15:0]      crc_out,
  output logic             crc_valid,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LEN = CNT_W'(CHAIN_LEN);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_sreg, w_sreg_nxt;
  logic [3:0]       r_nib, w_nib_nxt;
  logic [CNT_W-1:0] r_bit_count, w_bit_count_nxt;
  logic             r_ccff_head, r_shift_en;
  logic [CNT_W-1:0] w_cnt_inc, w_left;
  logic [3:0]       w_nib_load;
  logic             w_start_ok;

  assign w_cnt_inc  = r_bit_count + CNT_W'(1);
  // Bits still owed to the chain once the current shift (if any) lands.
  assign w_left     = LP_LEN - ((r_state == S_SHIFT) ? w_cnt_inc : r_bit_count);
  assign w_nib_load = (w_left >= CNT_W'(8)) ? 4'd8 : w_left[3:0];
  assign w_start_ok = start && !abort && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state     <= S_IDLE;
      r_sreg      <= 8'd0;
      r_nib       <= 4'd0;
      r_bit_count <= '0;
      r_ccff_head <= 1'b0;
      r_shift_en  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_nib       <= w_nib_nxt;
      r_bit_count <= w_bit_count_nxt;
      r_shift_en  <= (w_state_nxt == S_SHIFT);
      if (w_state_nxt == S_SHIFT) r_ccff_head <= w_sreg_nxt[7];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_nib_nxt       = r_nib;
    w_bit_count_nxt = r_bit_count;
    s_ready         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_bit_count_nxt = '0;
          w_state_nxt     = S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_sreg_nxt  = s_data;
          w_nib_nxt   = w_nib_load;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sreg_nxt      = {r_sreg[6:0], 1'b0};
        w_nib_nxt       = r_nib - 4'd1;
        w_bit_count_nxt = w_cnt_inc;
        if (r_nib == 4'd1) begin
          if (w_cnt_inc == LP_LEN) begin
            w_state_nxt = S_DONE;
          end else begin
            // Accepting on the last bit keeps the chain clock running with no bubble.
            s_ready = 1'b1;
            if (s_valid) begin
              w_sreg_nxt = s_data;
              w_nib_nxt  = w_nib_load;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_sreg_nxt      = r_sreg;
      w_nib_nxt       = r_nib;
      w_bit_count_nxt = r_bit_count;
      s_ready         = 1'b0;
    end
  end

  assign ccff_head      = r_ccff_head;
  assign chain_shift_en = r_shift_en;
  assign busy           = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign done           = (r_state == S_DONE);
  assign bit_count      = r_bit_count;

`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ ccff_tail;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_crc <= 16'hFFFF;
    end else if (w_start_ok) begin
      r_crc <= 16'hFFFF;
    end else if (r_shift_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign crc_out   = r_crc;
  assign crc_valid = (r_state == S_DONE);
`else
  logic w_unused_tail;
  logic w_unused_start_ok;
  assign w_unused_tail     = ccff_tail;
  assign w_unused_start_ok = w_start_ok;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - randomized bench with bit-stream model for ccff_bitstream_loader
// Covers the CCFF_READBACK_CRC_EN ports when that macro is defined.
module tb_ccff_bitstream_loader;

  localparam int CL = 20;

  logic       prog_clk = 1'b0;
  logic       prog_reset, start, abort, s_valid, ccff_tail;
  logic [7:0] s_data;
  logic       s_ready, ccff_head, chain_shift_en, busy, done;
  logic [7:0] bit_count;
`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] crc_out;
  logic        crc_valid;
`endif

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .CNT_W(8)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .chain_shift_en(chain_shift_en), .ccff_tail(ccff_tail),
`ifdef CCFF_READBACK_CRC_EN
    .crc_out(crc_out), .crc_valid(crc_valid),
`endif
    .busy(busy), .done(done), .bit_count(bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a load is a bit stream built from the accepted bytes, truncated to CL.
  int          m_n, m_loaded, m_acc;
  bit          m_active, m_done;
  logic        m_bits [0:31];
  logic [15:0] m_crc;
  bit          hs_flag;
  bit          cap [$];
  int          runs [$];
  int          run;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  always @(negedge prog_clk) begin
    bit exp_shift, exp_ready;
    if (prog_reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_shift_en", chain_shift_en, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_head", ccff_head, 0);
      chk("rst_bit_count", bit_count, 0);
`ifdef CCFF_READBACK_CRC_EN
      chk("rst_crc", crc_out, 16'hFFFF);
      chk("rst_crc_valid", crc_valid, 0);
`endif
      m_active = 0; m_done = 0; m_n = 0; m_loaded = 0; m_acc = 0;
      m_crc = 16'hFFFF; hs_flag = 0; cap.delete(); run = 0;
    end else begin
      exp_shift = m_active && (m_loaded > m_n);
      exp_ready = m_active && !abort && (m_loaded - m_n <= 1) && (m_loaded < CL);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("bit_count", bit_count, m_n);
      chk("shift_en", chain_shift_en, exp_shift);
      chk("s_ready", s_ready, exp_ready);
      if (exp_shift) chk("head", ccff_head, m_bits[m_n]);
      if (!chain_shift_en && cap.size() > 0) chk("head_hold", ccff_head, cap[$]);
`ifdef CCFF_READBACK_CRC_EN
      chk("crc", crc_out, m_crc);
      chk("crc_valid", crc_valid, m_done);
`endif
      if (chain_shift_en) begin
        cap.push_back(ccff_head);
        run++;
      end else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      hs_flag = s_valid && exp_ready;
      if (abort) begin
        m_active = 0; m_done = 0;
      end else if (start && !m_active) begin
        m_active = 1; m_done = 0; m_n = 0; m_loaded = 0; m_acc = 0; m_crc = 16'hFFFF;
      end else if (m_active) begin
        if (exp_shift) begin
          m_crc = crc_step(m_crc, ccff_tail);
          m_n++;
        end
        if (hs_flag) begin
          for (int b = 0; b < 8; b++)
            if (m_acc < 4) m_bits[8*m_acc + b] = s_data[7-b];
          m_acc++;
          m_loaded = (m_loaded + 8 > CL) ? CL : m_loaded + 8;
        end
        if (m_n == CL) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  // Byte source: holds the head of src_q until the model reports a handshake.
  logic [7:0] src_q [$];
  int stall_req = 0, stall_cnt = 0;
  bit rnd_gaps = 0, rnd_tail = 0;

  always begin
    @(posedge prog_clk); #2;
    if (hs_flag && src_q.size() > 0) begin
      void'(src_q.pop_front());
      if (stall_req > 0) begin
        stall_cnt = stall_req;
        stall_req = 0;
      end
    end
    if (stall_cnt > 0) begin
      s_valid = 0;
      stall_cnt--;
    end else if (src_q.size() > 0 && (!rnd_gaps || $urandom_range(0, 3) != 0)) begin
      s_valid = 1;
      s_data  = src_q[0];
    end else begin
      s_valid = 0;
      s_data  = 8'($urandom);
    end
    if (rnd_tail) ccff_tail = 1'($urandom_range(0, 1));
  end

  task automatic cyc();
    @(posedge prog_clk); #3;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic wait_settle(input int budget);
    int i = 0;
    while (m_active && i < budget) begin cyc(); i++; end
    chk("settle_timeout", m_active, 0);
    cyc();
  endtask

  function automatic logic [19:0] cap20();
    logic [19:0] v = '0;
    for (int i = 0; i < 20 && i < cap.size(); i++) v[19-i] = cap[i];
    return v;
  endfunction

  initial begin
    int i;
    prog_reset = 1; start = 0; abort = 0; s_valid = 0; s_data = 0; ccff_tail = 0;
    repeat (2) cyc();
    prog_reset = 0;
    cyc();

    // Continuous stream, partial final byte (20 = 2 bytes + 4 bits of 0xF0).
    cap.delete(); runs.delete();
    src_q = '{8'hA5, 8'h3C, 8'hF0};
    pulse_start();
    wait_settle(200);
    chk("A_bits", cap20(), 20'hA53CF);
    chk("A_nbits", cap.size(), 20);
    chk("A_runs", runs.size(), 1);
    if (runs.size() > 0) chk("A_run_len", runs[0], 20);
    chk("A_done", done, 1);
    chk("A_bit_count", bit_count, 20);

    // Source stalls after the first byte; the bit pattern must not change.
    cap.delete(); runs.delete();
    src_q = '{8'hA5, 8'h3C, 8'hF0};
    stall_req = 13;
    pulse_start();
    wait_settle(200);
    chk("S_bits", cap20(), 20'hA53CF);
    chk("S_runs", runs.size(), 2);
    if (runs.size() > 0) chk("S_run0", runs[0], 8);
    chk("S_done", done, 1);

    // Start while shifting is ignored; abort at bit 5 holds bit_count.
    src_q = '{8'hC3, 8'h5A, 8'h99};
    pulse_start();
    i = 0; while (bit_count != 2 && i < 100) begin cyc(); i++; end
    chk("B_reach2", bit_count, 2);
    pulse_start();
    i = 0; while (bit_count != 5 && i < 100) begin cyc(); i++; end
    chk("B_reach5", bit_count, 5);
    abort = 1; cyc(); abort = 0;
    chk("B_busy", busy, 0);
    chk("B_shift_en", chain_shift_en, 0);
    chk("B_done", done, 0);
    chk("B_bit_count_held", bit_count, 5);
    start = 1; abort = 1; cyc(); start = 0; abort = 0;
    chk("B_abort_wins", busy, 0);
    src_q.delete(); cap.delete();
    src_q = '{8'hC3, 8'h5A, 8'h99};
    pulse_start();
    wait_settle(200);
    chk("B_restart_bits", cap20(), 20'hC35A9);
    chk("B_restart_count", bit_count, 20);

    // Random loads with gaps, tail data, spurious starts and rare aborts.
    rnd_gaps = 1; rnd_tail = 1;
    for (int r = 0; r < 10; r++) begin
      src_q.delete();
      for (int k = 0; k < 4; k++) src_q.push_back(8'($urandom));
      pulse_start();
      i = 0;
      while (m_active && i < 300) begin
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 79) == 0);
        cyc(); i++;
      end
      start = 0; abort = 0;
      chk("R_timeout", m_active, 0);
      cyc();
    end
    rnd_gaps = 0; rnd_tail = 0;

    // Asynchronous reset between edges mid-shift.
    src_q.delete();
    src_q = '{8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    i = 0; while (!chain_shift_en && i < 50) begin cyc(); i++; end
    chk("AR_shifting", chain_shift_en, 1);
    prog_reset = 1;
    #1;
    chk("AR_shift_en", chain_shift_en, 0);
    chk("AR_head", ccff_head, 0);
    chk("AR_busy", busy, 0);
    chk("AR_s_ready", s_ready, 0);
    chk("AR_bit_count", bit_count, 0);
`ifdef CCFF_READBACK_CRC_EN
    chk("AR_crc", crc_out, 16'hFFFF);
`endif
    cyc();
    prog_reset = 0;
    src_q.delete();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
